// File: rtl/uart_rx_host.sv
// Host-side UART receiver: 16x oversampled 8-bit frames with optional parity,
// buffered in a first-word-fall-through FIFO with sticky error flags.
module uart_rx_host #(
  parameter int unsigned SYS_CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned PARITY_MODE  = 1,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          err_clr
);
  localparam int unsigned DIV = SYS_CLK_FREQ / (BAUD_RATE * 16);
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DivMax  = DW'(DIV - 1);
  localparam logic [PW:0]   FullCnt = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e        r_state, w_state_next;
  logic          r_sync1, r_rxs, r_rxs_prev;
  logic [DW-1:0] r_div_cnt;
  logic [3:0]    r_os;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par_bit, r_stop_bit, r_done;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_count;
  logic          r_perr, r_ferr, r_ovf;

  logic w_tick, w_mid, w_end, w_state_chg;
  logic w_par_ok, w_good, w_push, w_pop;

  assign w_tick      = (r_div_cnt == DivMax);
  assign w_mid       = w_tick && (r_os == 4'd7);
  assign w_end       = w_tick && (r_os == 4'd15);
  assign w_state_chg = (w_state_next != r_state);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (r_rxs_prev && !r_rxs) w_state_next = StStart;
      StStart:  if (w_mid) w_state_next = r_rxs ? StIdle : StData;
      StData:   if (w_end && (r_bit_cnt == 3'd7)) begin
                  w_state_next = (PARITY_MODE != 0) ? StParity : StStop;
                end
      StParity: if (w_end) w_state_next = StStop;
      StStop:   if (w_end) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_sync1    <= 1'b1;
      r_rxs      <= 1'b1;
      r_rxs_prev <= 1'b1;
      r_div_cnt  <= '0;
      r_os       <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_stop_bit <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sync1    <= rx;
      r_rxs      <= r_sync1;
      r_rxs_prev <= r_rxs;
      r_done     <= 1'b0;
      // Baud phase is anchored to the start edge by holding the divider in idle.
      if (r_state == StIdle || w_tick) r_div_cnt <= '0;
      else                             r_div_cnt <= r_div_cnt + 1'b1;
      if (r_state == StIdle || w_state_chg) r_os <= '0;
      else if (w_tick)                      r_os <= r_os + 4'd1;
      if (r_state == StStart) r_bit_cnt <= '0;
      else if (r_state == StData && w_end) r_bit_cnt <= r_bit_cnt + 3'd1;
      if (r_state == StData && w_end) r_shift <= {r_rxs, r_shift[7:1]};
      if (r_state == StParity && w_end) r_par_bit <= r_rxs;
      if (r_state == StStop && w_end) begin
        r_stop_bit <= r_rxs;
        r_done     <= 1'b1;
      end
    end
  end

  always_comb begin
    w_par_ok = 1'b1;
    if (PARITY_MODE == 1)      w_par_ok = (^r_shift ^ r_par_bit) == 1'b1;
    else if (PARITY_MODE == 2) w_par_ok = (^r_shift ^ r_par_bit) == 1'b0;
  end

  assign w_good = r_done && r_stop_bit && w_par_ok;
  assign w_pop  = rd_en && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push = w_good && (!full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= r_shift;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (r_done && !w_par_ok)   r_perr <= 1'b1;
      else if (err_clr)          r_perr <= 1'b0;
      if (r_done && !r_stop_bit) r_ferr <= 1'b1;
      else if (err_clr)          r_ferr <= 1'b0;
      if (w_good && full && !w_pop) r_ovf <= 1'b1;
      else if (err_clr)             r_ovf <= 1'b0;
    end
  end

  assign rd_data    = r_mem[r_rptr];
  assign count      = r_count;
  assign empty      = (r_count == '0);
  assign full       = (r_count == FullCnt);
  assign busy       = (r_state != StIdle);
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overflow   = r_ovf;
endmodule

// File: tb/tb_uart_rx_host.sv
// Directed bench for uart_rx_host at 16 clocks per bit with odd parity.
module tb_uart_rx_host;
  logic       clk, rst, rx, rd_en, err_clr;
  logic [7:0] rd_data;
  logic       empty, full, busy, parity_err, frame_err, overflow;
  logic [3:0] count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int empty_fall_cyc = 0;
  logic prev_empty = 1'b1;

  uart_rx_host #(
    .SYS_CLK_FREQ(1_600_000),
    .BAUD_RATE   (100_000),
    .PARITY_MODE (1),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .busy      (busy),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overflow  (overflow),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (prev_empty && !empty) empty_fall_cyc = cyc;
    prev_empty = empty;
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_push;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    @(posedge clk); #1;
    fall_cyc = cyc;
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic pop();
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
  endtask

  task automatic clr_err();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_perr"}, parity_err, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    int d;
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    // First frame also measures rx-fall to empty-fall latency.
    send_frame(8'hA5, 1'b1, 1'b1);
    d = empty_fall_cyc - fall_cyc;
    n_checks++;
    if (d < 171 || d > 177) begin
      n_errors++;
      $display("FAIL latency: got %0d cycles, required 171..177", d);
    end
    check("lat_rd_data", rd_data, 8'hA5);
    pop();
    check("lat_empty", empty, 1);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
      check($sformatf("v%0d_count", i), count, {3'b0, vecs[i].exp_push});
      check($sformatf("v%0d_perr", i), parity_err, vecs[i].exp_perr);
      check($sformatf("v%0d_ferr", i), frame_err, vecs[i].exp_ferr);
      check($sformatf("v%0d_ovf", i), overflow, 0);
      if (vecs[i].exp_push) begin
        check($sformatf("v%0d_rd_data", i), rd_data, vecs[i].data);
        pop();
      end
      check($sformatf("v%0d_empty", i), empty, 1);
      clr_err();
      check($sformatf("v%0d_perr_clr", i), parity_err, 0);
      check($sformatf("v%0d_ferr_clr", i), frame_err, 0);
    end

    // Nine good bytes into an eight-slot FIFO.
    for (int i = 0; i < 9; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send_frame(b, ~^b, 1'b1);
    end
    check("ovf_full", full, 1);
    check("ovf_count", count, 8);
    check("ovf_flag", overflow, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_pop%0d", i), rd_data, i);
      pop();
    end
    check("ovf_empty", empty, 1);
    check("ovf_sticky", overflow, 1);
    clr_err();
    check("ovf_clr", overflow, 0);

    // 4-cycle glitch: false start.
    @(posedge clk); #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    check("glitch_busy", busy, 1);
    repeat (20) @(posedge clk);
    #1;
    check("glitch_idle", busy, 0);
    check("glitch_count", count, 0);

    // Reset during DATA with one byte already buffered.
    send_frame(8'h12, 1'b1, 1'b1);
    check("pre_rst_count", count, 1);
    @(posedge clk); #1 rx = 1'b0;
    repeat (16 + 48) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    rst = 1'b1; rx = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_busy", busy, 0);
    send_frame(8'h7E, 1'b1, 1'b1);
    check("post_rst_count", count, 1);
    check("post_rst_data", rd_data, 8'h7E);
    check("post_rst_perr", parity_err, 0);
    check("post_rst_ferr", frame_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
